// File: rtl/legv8_cache_pkg.sv
// Shared FSM encodings and sizing helpers for the LEGv8 set-associative tag controller.
package legv8_cache_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOOKUP    = 2'd1;
  localparam logic [1:0] ST_MISS_WAIT = 2'd2;
  localparam logic [1:0] ST_FLUSH     = 2'd3;

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  // Packed per-set reset ages: way i holds age i, ww bits per way, way 0 in the low bits.
  function automatic logic [23:0] reset_ages(input int ways, input int ww);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < ways; i++)
      for (int b = 0; b < ww; b++)
        v[i*ww+b] = ((i >> b) & 1) != 0;
    return v;
  endfunction

endpackage

// File: rtl/legv8_cache_lru.sv
// Combinational true-LRU age update for one set; zero latency, no flow control.
module legv8_cache_lru
  import legv8_cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS*WAY_W-1:0] ages_i,
  input  logic [WAY_W-1:0]      way_i,
  input  logic                  en_i,
  output logic [WAYS*WAY_W-1:0] ages_o,
  output logic [WAY_W-1:0]      lru_way_o
);

  logic [WAY_W-1:0] acc_age;

  always_comb begin
    acc_age   = ages_i[way_i*WAY_W +: WAY_W];
    ages_o    = ages_i;
    lru_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages_i[w*WAY_W +: WAY_W] == WAY_W'(WAYS-1))
        lru_way_o = WAY_W'(w);
      if (en_i) begin
        if (WAY_W'(w) == way_i)
          ages_o[w*WAY_W +: WAY_W] = '0;
        else if (ages_i[w*WAY_W +: WAY_W] < acc_age)
          ages_o[w*WAY_W +: WAY_W] = ages_i[w*WAY_W +: WAY_W] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/legv8_cache_tag_ctrl.sv
// N-way tag controller: valid/tag/LRU storage, lookup -> hit or miss/fill, whole-cache flush.
// Hit response 2 cycles after accept; req_ready only in IDLE with no flush due; mem_req held until fill_ack.
module legv8_cache_tag_ctrl
  import legv8_cache_pkg::*;
#(
  parameter int WAYS    = 4,
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 57,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [INDEX_W-1:0]     req_index,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [way_w(WAYS)-1:0] resp_way,
  output logic                   mem_req,
  output logic [INDEX_W-1:0]     mem_index,
  output logic [TAG_W-1:0]       mem_tag,
  input  logic                   fill_ack,
  input  logic                   flush,
  output logic                   flush_busy,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  localparam int WAY_W  = way_w(WAYS);
  localparam int SETS   = 1 << INDEX_W;
  localparam int AGE_VW = WAYS * WAY_W;
  localparam logic [AGE_VW-1:0] RST_AGES = AGE_VW'(reset_ages(WAYS, WAY_W));

  logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [AGE_VW-1:0] age_q   [SETS];

  logic [1:0]         state_q, state_d;
  logic [INDEX_W-1:0] lat_idx_q, lat_idx_d;
  logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
  logic [WAY_W-1:0]   victim_q, victim_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]   resp_way_q, resp_way_d;
  logic               mem_req_q, mem_req_d;
  logic               flush_pend_q, flush_pend_d;
  logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic               hit, inv_found, upd_en, fill_now;
  logic [WAY_W-1:0]   hit_way, inv_way, lru_way, victim, upd_way;
  logic [AGE_VW-1:0]  ages_new;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[lat_idx_q][w] && tag_mem[lat_idx_q][w] == lat_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[lat_idx_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim   = inv_found ? inv_way : lru_way;
  assign fill_now = (state_q == ST_MISS_WAIT) && fill_ack;
  assign upd_en   = ((state_q == ST_LOOKUP) && hit) || fill_now;
  assign upd_way  = (state_q == ST_LOOKUP) ? hit_way : victim_q;

  legv8_cache_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .ages_i    (age_q[lat_idx_q]),
    .way_i     (upd_way),
    .en_i      (upd_en),
    .ages_o    (ages_new),
    .lru_way_o (lru_way)
  );

  always_comb begin
    state_d      = state_q;
    lat_idx_d    = lat_idx_q;
    lat_tag_d    = lat_tag_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    mem_req_d    = mem_req_q;
    flush_pend_d = flush_pend_q;
    flush_cnt_d  = flush_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = ST_FLUSH;
          flush_pend_d = 1'b0;
          flush_cnt_d  = '0;
        end else if (req_valid) begin
          state_d   = ST_LOOKUP;
          lat_idx_d = req_index;
          lat_tag_d = req_tag;
        end
      end
      ST_LOOKUP: begin
        if (flush) flush_pend_d = 1'b1;
        if (hit) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_way_d   = hit_way;
          hit_cnt_d    = hit_cnt_q + CNT_W'(1);
        end else begin
          state_d    = ST_MISS_WAIT;
          victim_d   = victim;
          mem_req_d  = 1'b1;
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      ST_MISS_WAIT: begin
        if (flush) flush_pend_d = 1'b1;
        if (fill_ack) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_way_d   = victim_q;
          mem_req_d    = 1'b0;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + INDEX_W'(1);
        if (flush_cnt_q == INDEX_W'(SETS-1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lat_idx_q    <= '0;
      lat_tag_q    <= '0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      mem_req_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_idx_q    <= lat_idx_d;
      lat_tag_q    <= lat_tag_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      mem_req_q    <= mem_req_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Valid bits and ages are reset; tags are plain storage qualified by valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        age_q[s]   <= RST_AGES;
      end
    end else if (state_q == ST_FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
      age_q[flush_cnt_q]   <= RST_AGES;
    end else if (upd_en) begin
      age_q[lat_idx_q] <= ages_new;
      if (fill_now) valid_q[lat_idx_q][victim_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_now) tag_mem[lat_idx_q][victim_q] <= lat_tag_q;
  end

  assign req_ready  = (state_q == ST_IDLE) && !flush && !flush_pend_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign mem_req    = mem_req_q;
  assign mem_index  = lat_idx_q;
  assign mem_tag    = lat_tag_q;
  assign flush_busy = (state_q == ST_FLUSH);
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/legv8_cache_tag_ctrl.md
Name: legv8_cache_tag_ctrl

Overview:
Parametrised N-way set-associative cache tag controller. It replaces the purely combinational hit detector with a clocked block that holds valid bits, tags and per-set true-LRU ages. It runs a lookup/miss/fill handshake with the memory side and supports whole-cache flush. It sits between the LEGv8 load/store stage (request side) and the memory fill path.

Parameters:
WAYS, 4, associativity; power of 2, 2..8
INDEX_W, 5, set index width; 2**INDEX_W sets
TAG_W, 57, tag width
CNT_W, 32, width of hit/miss statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request
req_ready  out  1  = (state==IDLE) && !flush && !flush_pend
req_index  in  INDEX_W  set index
req_tag  in  TAG_W  tag
resp_valid  out  1  one-cycle response pulse
resp_hit  out  1  1=hit, 0=miss serviced by fill
resp_way  out  log2(WAYS)  way hit or filled
mem_req  out  1  miss request, level, held until fill_ack
mem_index  out  INDEX_W  latched index during MISS_WAIT
mem_tag  out  TAG_W  latched tag during MISS_WAIT
fill_ack  in  1  memory has delivered the line
flush  in  1  invalidate-all request pulse
flush_busy  out  1  high while flushing
hit_cnt  out  CNT_W  hits since reset, wraps
miss_cnt  out  CNT_W  misses since reset, wraps

Behaviour:
- Reset (rst low, async): all valid bits = 0; way i age = i in every set; state = IDLE; resp_valid, resp_hit, resp_way, mem_req, flush_busy, flush_pend, counters = 0. Tag storage is not cleared.
- FSM states: IDLE, LOOKUP, MISS_WAIT, FLUSH.
- IDLE: a request is accepted on req_valid && req_ready at an edge. Index and tag are latched and the state moves to LOOKUP. flush (or flush_pend) in IDLE moves to FLUSH. Flush takes priority over a simultaneous request.
- LOOKUP, 1 cycle: hit = any way with valid && tag==latched tag. On multiple matches (illegal), the lowest way wins.
  - Hit: at the next edge, resp_valid=1, resp_hit=1, resp_way=way, LRU updated, hit_cnt+1, state goes to IDLE.
  - Miss: at the next edge, victim chosen = lowest invalid way, else the way with age==WAYS-1. The victim is latched, mem_req=1, miss_cnt+1, state goes to MISS_WAIT.
- Hit latency: resp_valid is high in the 2nd cycle after the accept edge. Back-to-back throughput is one request per 2 cycles.
- MISS_WAIT: mem_req, mem_index and mem_tag are held stable. On fill_ack at an edge: tag written to the victim, valid set, LRU updated, resp_valid=1, resp_hit=0, resp_way=victim, mem_req=0, state goes to IDLE. fill_ack outside MISS_WAIT is ignored.
- LRU update for accessed way w with old age a: age[w]=0; every way with age<a gets age+1; others are unchanged. Ages in a set are always a permutation of 0..WAYS-1.
- flush seen outside IDLE sets flush_pend. The current operation completes normally, then FLUSH starts.
- FLUSH: a set counter runs 0 to 2**INDEX_W-1, one set per cycle. Each set gets valid=0 and ages reset to i. flush_busy=1 throughout, so the flush lasts exactly 2**INDEX_W cycles. flush_pend is cleared on entry. A flush pulse during FLUSH is ignored. After the last set, state goes to IDLE.
- resp_valid is deasserted the cycle after any pulse. Counters wrap at 2**CNT_W.
- Reset mid-operation (any state): immediate return to reset values. mem_req drops asynchronously and the pending miss is abandoned.

Decomposition:
- Package legv8_cache_pkg holds: the FSM state enum; WAY_W = $clog2(WAYS) as a localparam function; a reset-age helper function.
- One sub-module, legv8_cache_lru: combinational per-set age update. Inputs are the age vector, accessed way and update enable. Outputs are the new age vector and the LRU way (age==WAYS-1).
- Tag/valid/age arrays and the FSM stay in legv8_cache_tag_ctrl.

Test Plan:
- Reset, then lookup idx 3 tag 0x1234 -> mem_req=1, mem_index=3, mem_tag=0x1234. fill_ack after 5 cycles -> resp hit=0 way=0. Repeat lookup -> resp hit=1 way=0; hit_cnt=1, miss_cnt=1.
- Fill idx 7 with tags A,B,C,D (ways 0..3), then hit A, then look up E -> miss, victim way 1 (B is LRU). Lookup B -> miss; lookup A -> hit way 0.
- Same tag 0x55 at idx 0 and idx 31 -> both miss and fill way 0 independently. Second lookups both hit.
- flush pulsed during MISS_WAIT -> fill completes with resp hit=0, then flush_busy=1 for exactly 32 cycles with req_ready=0. Lookup of a previously filled tag then misses.
- rst low during MISS_WAIT -> mem_req=0 asynchronously. After release, state IDLE, req_ready=1, all lookups miss, counters=0.
- flush and req_valid in the same IDLE cycle -> request not accepted (req_ready=0). Request accepted in the first cycle after flush_busy falls.
